// File: rtl/status_register.sv
// Processor status flags (C, Z, I, D, V, N) with prioritised update sources
// and a delayed interrupt mask that commits only at instruction boundaries.
module status_register #(
    parameter logic [7:0] RESET_P = 8'h04
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_carry,
    input  logic       alu_zero,
    input  logic       alu_negative,
    input  logic       alu_overflow,
    input  logic       update_c,
    input  logic       update_z,
    input  logic       update_n,
    input  logic       update_v,
    input  logic [2:0] flag_op,
    input  logic       load_from_bus,
    input  logic       bit_test,
    input  logic [7:0] data_bus_in,
    input  logic       interrupt_entry,
    input  logic       instruction_boundary,
    input  logic       push_brk,
    output logic       carry_flag,
    output logic       zero_flag,
    output logic       irq_flag,
    output logic       decimal_flag,
    output logic       overflow_flag,
    output logic       negative_flag,
    output logic [7:0] status_out,
    output logic       irq_mask_effective
);

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_SEC  = 3'd1;
    localparam logic [2:0] OP_CLC  = 3'd2;
    localparam logic [2:0] OP_SEI  = 3'd3;
    localparam logic [2:0] OP_CLI  = 3'd4;
    localparam logic [2:0] OP_SED  = 3'd5;
    localparam logic [2:0] OP_CLD  = 3'd6;
    localparam logic [2:0] OP_CLV  = 3'd7;

    logic carry_r, zero_r, irq_r, decimal_r, overflow_r, negative_r, mask_r;
    logic carry_s, zero_s, irq_s, decimal_s, overflow_s, negative_s;
    logic [1:0] unused_bus_bits_s;

    assign unused_bus_bits_s = data_bus_in[5:4];

    // Next-state flags: bus load blocks everything, otherwise each flag takes
    // its highest-priority active source and the rest fall through.
    always_comb begin
        carry_s    = carry_r;
        zero_s     = zero_r;
        irq_s      = irq_r;
        decimal_s  = decimal_r;
        overflow_s = overflow_r;
        negative_s = negative_r;
        if (load_from_bus) begin
            carry_s    = data_bus_in[0];
            zero_s     = data_bus_in[1];
            irq_s      = data_bus_in[2];
            decimal_s  = data_bus_in[3];
            overflow_s = data_bus_in[6];
            negative_s = data_bus_in[7];
        end else begin
            if (update_c) begin
                carry_s = alu_carry;
            end else begin
                carry_s = carry_r;
            end
            if (update_z) begin
                zero_s = alu_zero;
            end else begin
                zero_s = zero_r;
            end
            if (bit_test) begin
                negative_s = data_bus_in[7];
                overflow_s = data_bus_in[6];
            end else begin
                if (update_n) begin
                    negative_s = alu_negative;
                end else begin
                    negative_s = negative_r;
                end
                if (update_v) begin
                    overflow_s = alu_overflow;
                end else begin
                    overflow_s = overflow_r;
                end
            end
            case (flag_op)
                OP_NONE: carry_s    = carry_s;
                OP_SEC:  carry_s    = 1'b1;
                OP_CLC:  carry_s    = 1'b0;
                OP_SEI:  irq_s      = 1'b1;
                OP_CLI:  irq_s      = 1'b0;
                OP_SED:  decimal_s  = 1'b1;
                OP_CLD:  decimal_s  = 1'b0;
                OP_CLV:  overflow_s = 1'b0;
                default: carry_s    = carry_s;
            endcase
            if (interrupt_entry) begin
                irq_s = 1'b1;
            end else begin
                irq_s = irq_s;
            end
        end
    end

    // Flag and effective-mask registers; the mask lags I until a boundary
    // except on interrupt entry, where both rise together.
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_r    <= RESET_P[0];
            zero_r     <= RESET_P[1];
            irq_r      <= RESET_P[2];
            decimal_r  <= RESET_P[3];
            overflow_r <= RESET_P[6];
            negative_r <= RESET_P[7];
            mask_r     <= 1'b1;
        end else begin
            carry_r    <= carry_s;
            zero_r     <= zero_s;
            irq_r      <= irq_s;
            decimal_r  <= decimal_s;
            overflow_r <= overflow_s;
            negative_r <= negative_s;
            if (instruction_boundary || interrupt_entry) begin
                mask_r <= irq_s;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    assign carry_flag         = carry_r;
    assign zero_flag          = zero_r;
    assign irq_flag           = irq_r;
    assign decimal_flag       = decimal_r;
    assign overflow_flag      = overflow_r;
    assign negative_flag      = negative_r;
    assign irq_mask_effective = mask_r;
    assign status_out = {negative_r, overflow_r, 1'b1, push_brk,
                         decimal_r, irq_r, zero_r, carry_r};

endmodule
